// File: rtl/fc_dot_engine.sv
// fc_dot_engine: read-side sequencer + signed fixed-point MAC for one neuron.
// Drives RAM port A (input vector) and port B (weight row), accumulates
// bias<<<FRAC plus sum(x*w), then returns sat(acc>>>FRAC) via valid/ready.
// Optional feature macro: FC_RELU_EN (clamp negative results to zero).
module fc_dot_engine #(
  parameter int RAM_DEEP = 40,
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = $clog2(RAM_DEEP),
  parameter int FRAC     = 8,
  parameter int ACC_W    = 2*DWIDTH+AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH:0]   len,
  input  logic [AWIDTH-1:0] xbase,
  input  logic [AWIDTH-1:0] wbase,
  input  logic [DWIDTH-1:0] bias,
  output logic              busy,
  output logic              rea,
  output logic              reb,
  output logic [AWIDTH-1:0] addra,
  output logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] douta,
  input  logic [DWIDTH-1:0] doutb,
  input  logic              dvalida,
  input  logic              dvalidb,
  output logic [DWIDTH-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_t;

  localparam logic [AWIDTH-1:0] LAST_A = AWIDTH'(RAM_DEEP-1);
  localparam logic [AWIDTH:0]   DEEP_L = (AWIDTH+1)'(RAM_DEEP);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [AWIDTH:0]          cnt_q, cnt_d;
  logic [AWIDTH:0]          len_q, len_d;
  logic [AWIDTH-1:0]        addra_q, addra_d;
  logic [AWIDTH-1:0]        addrb_q, addrb_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DWIDTH-1:0]        result_q, result_d;
  logic                     err_q, err_d;

  logic [AWIDTH:0]            len_eff;
  logic [AWIDTH-1:0]          xbase_m, wbase_m;
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, bias_acc, acc_sum;
  logic                       both_vld;

  // Shift out the fraction (floor), clamp to DWIDTH, optionally ReLU.
  function automatic logic [DWIDTH-1:0] fmt(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DWIDTH-1:0]       r;
    s = a >>> FRAC;
    if (s > SAT_MAX)      r = SAT_MAX[DWIDTH-1:0];
    else if (s < SAT_MIN) r = SAT_MIN[DWIDTH-1:0];
    else                  r = s[DWIDTH-1:0];
`ifdef FC_RELU_EN
    if (r[DWIDTH-1]) r = '0;
`endif
    return r;
  endfunction

  // Address step with wrap at the top of the RAM.
  function automatic logic [AWIDTH-1:0] inc_a(input logic [AWIDTH-1:0] a);
    return (a >= LAST_A) ? '0 : a + 1'b1;
  endfunction

  // Datapath helpers: clamped length, base addresses reduced into range,
  // sign-extended product and bias.
  always_comb begin
    len_eff  = (len > DEEP_L) ? DEEP_L : len;
    xbase_m  = ({1'b0, xbase} >= DEEP_L) ? xbase - LAST_A - 1'b1 : xbase;
    wbase_m  = ({1'b0, wbase} >= DEEP_L) ? wbase - LAST_A - 1'b1 : wbase;
    prod     = $signed(douta) * $signed(doutb);
    prod_ext = {{(ACC_W-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
    bias_ext = {{(ACC_W-DWIDTH){bias[DWIDTH-1]}}, bias};
    bias_acc = bias_ext <<< FRAC;
    both_vld = dvalida & dvalidb;
    acc_sum  = acc_q + (both_vld ? prod_ext : '0);
  end

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    addra_d  = addra_q;
    addrb_d  = addrb_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q | (dvalida ^ dvalidb);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          len_d   = len_eff;
          cnt_d   = '0;
          addra_d = xbase_m;
          addrb_d = wbase_m;
          acc_d   = bias_acc;
          if (len_eff == '0) begin
            result_d = fmt(bias_acc);
            state_d  = S_OUT;
          end else begin
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        acc_d   = acc_sum;
        addra_d = inc_a(addra_q);
        addrb_d = inc_a(addrb_q);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Last read data lands here; fold it in and register the result.
        acc_d    = acc_sum;
        result_d = fmt(acc_sum);
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      addra_q  <= addra_d;
      addrb_q  <= addrb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign rea          = (state_q == S_READ);
  assign reb          = (state_q == S_READ);
  assign addra        = addra_q;
  assign addrb        = addrb_q;
  assign result       = result_q;
  assign result_valid = (state_q == S_OUT);
  assign err          = err_q;

endmodule

// File: doc/fc_dot_engine.md
# fc_dot_engine

Read-side sequencer and multiply-accumulate stage of the fully-connected IP. It sits directly downstream of the dual-port activation/weight RAM and drives both RAM read ports: port A for the input vector, port B for the weight row. It accumulates the signed fixed-point dot product plus a bias and returns one saturated neuron output per `start` through a valid/ready handshake.

## Interface
- `RAM_DEEP`, 40: depth of the attached RAM, in words.
- `DWIDTH`, 16: width of data, weight, bias and result (signed, Qm.FRAC).
- `AWIDTH`, `$clog2(RAM_DEEP)`: RAM address width.
- `FRAC`, 8: fractional bits of the fixed-point format.
- `ACC_W`, `2*DWIDTH+AWIDTH`: accumulator width (signed).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `len` in AWIDTH+1: vector length, clamped to RAM_DEEP; sampled with `start`.
- `xbase` in AWIDTH: port-A start address of the input vector.
- `wbase` in AWIDTH: port-B start address of the weight row.
- `bias` in DWIDTH: signed bias; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `rea`, `reb` out 1: RAM read enables.
- `addra`, `addrb` out AWIDTH: RAM read addresses.
- `douta`, `doutb` in DWIDTH: RAM read data.
- `dvalida`, `dvalidb` in 1: RAM read-data valids.
- `result` out DWIDTH: saturated neuron output.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `err` out 1: sticky flag; set when exactly one of `dvalida`/`dvalidb` is high. Cleared only on `start`.

## Operation
- States: IDLE -> READ -> DRAIN -> OUT -> IDLE.
- IDLE, `start` with `len`>0: latch all inputs. Load the accumulator with `sign_ext(bias) <<< FRAC`. Go to READ.
- IDLE, `start` with `len`=0: the result is the saturated bias. Go directly to OUT.
- READ: assert `rea` and `reb` for exactly `len` cycles.
  - Index i = 0..len-1.
  - `addra` = (xbase+i) mod RAM_DEEP.
  - `addrb` = (wbase+i) mod RAM_DEEP. Addresses wrap past RAM_DEEP-1 to 0.
  - After the last address, go to DRAIN.
- Accumulate: on any cycle with `dvalida && dvalidb`, add `acc += signed(douta)*signed(doutb)`. The product is 2*DWIDTH wide, sign-extended to ACC_W.
- DRAIN, one cycle: the last product is accumulated. The result register is loaded from `sat(acc_final >>> FRAC)`. Go to OUT.
  - The shift is arithmetic, i.e. truncation toward negative infinity.
  - `sat` clamps to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- OUT: hold `result_valid`=1 with `result` stable until `result_ready`=1. On the handshake, go to IDLE.
- `start` outside IDLE is ignored, including in the cycle of the OUT handshake.
- `rea`/`reb` are low in every state other than READ.
- Reset, mid-operation or otherwise, aborts to IDLE. Every output returns to 0. There is no pending read or result.

## Timing
- Reset values: `busy`, `rea`, `reb`, `addra`, `addrb`, `result`, `result_valid` and `err` are all 0. The accumulator is 0.
- `start` sampled at edge T.
  - `rea`/`reb` are high in cycles T+1..T+len.
  - RAM data is valid in cycles T+2..T+len+1.
  - DRAIN is cycle T+len+1.
  - `result_valid` rises at cycle T+len+2.
- With `len`=0, `result_valid` rises at T+1.
- The earliest next `start` is the cycle after the handshake.
- `busy` rises at T+1 and falls the cycle after the handshake.
- RAM read latency is fixed at 1 cycle. The block relies on `dvalid` and does not count cycles.

## Configuration
- `FC_RELU_EN` defined: the saturated result passes through ReLU, so negative values become 0. The ReLU is applied before the result register, at no extra latency.
- `FC_RELU_EN` undefined: the signed saturated result is output unchanged.

## Test plan
- Basic dot product: FRAC=8, len=3, x=[256,512,-256], w=[256,256,256], bias=0.
  - Required: addresses xbase..xbase+2 issued; `result`=512; `result_valid` at T+5; `err`=0.
- Saturation: len=4, all x=w=32767.
  - Required: `result`=32767.
  - With w=-32768: `result`=-32768 without the macro, 0 with `FC_RELU_EN`.
- Backpressure: hold `result_ready` low for 10 cycles after `result_valid`.
  - Required: `result` stable, `busy`=1, a `start` pulse mid-hold ignored.
  - Release: handshake completes, then IDLE.
- Zero length and bias: len=0, bias=300.
  - Required: `rea`/`reb` never asserted; `result`=300 at T+1.
- Wrap and valid mismatch:
  - RAM_DEEP=40, wbase=38, len=4. Required: `addrb`=38,39,0,1.
  - Inject `dvalida` without `dvalidb`. Required: `err`=1 until the next `start`.
- Reset mid-operation: assert `rst_n`=0 during READ at i=2.
  - Required: all outputs 0 immediately.
  - A following start with len=1, x=256, w=256, bias=0 returns 256.
